// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared fetch-stage FSM state type, B opcode and PC step default.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  B_OPCODE        = 6'b000101;
    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit_if
// Brief  : Control, instruction-memory and IF/ID signals of the fetch unit.
// Rev    : 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               Start;
    logic [63:0]        StartPC;
    logic               Halt;
    logic [31:0]        IMemData;
    logic               Stall;
    logic               BranchTaken;
    logic [63:0]        BranchTarget;
    logic [63:0]        IMemAddr;
    logic [31:0]        IFID_Instr;
    logic [63:0]        IFID_PC;
    logic               IFID_Valid;
    logic [COUNT_W-1:0] FetchCount;
    logic               Running;

    modport master (
        output Start, StartPC, Halt, IMemData, Stall, BranchTaken, BranchTarget,
        input  IMemAddr, IFID_Instr, IFID_PC, IFID_Valid, FetchCount, Running
    );

    modport slave (
        input  Start, StartPC, Halt, IMemData, Stall, BranchTaken, BranchTarget,
        output IMemAddr, IFID_Instr, IFID_PC, IFID_Valid, FetchCount, Running
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_branch_predecode.sv
`default_nettype none
// ============================================================================
// Module : branch_predecode
// Brief  : Detects unconditional B and computes its PC-relative target.
// Rev    : 1.0
// ============================================================================
module branch_predecode
    import fetch_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [31:0] instr,
    output logic        is_b,
    output logic [63:0] target
);
    logic [63:0] w_offset;

    // imm26 is a word offset: sign-extend then scale to bytes
    assign w_offset = {{36{instr[25]}}, instr[25:0], 2'b00};
    assign is_b     = (instr[31:26] == B_OPCODE);
    assign target   = pc + w_offset;
endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Brief  : IF stage with IF/ID register; optional static B prediction when
//          STATIC_BRANCH_PREDICT_EN is defined.
// Rev    : 1.0
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT,
    parameter int unsigned COUNT_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    instr_fetch_unit_if.slave bus
);
    fetch_state_t       r_state;
    logic [63:0]        r_pc;
    logic [31:0]        r_instr;
    logic [63:0]        r_ifid_pc;
    logic               r_valid;
    logic [COUNT_W-1:0] r_count;
    logic               r_running;
    logic [63:0]        w_seq_pc;
    logic [63:0]        w_next_pc;

    assign w_seq_pc = r_pc + 64'(PC_STEP);

`ifdef STATIC_BRANCH_PREDICT_EN
    logic        w_is_b;
    logic [63:0] w_b_target;

    branch_predecode u_predecode (
        .pc     (r_pc),
        .instr  (bus.IMemData),
        .is_b   (w_is_b),
        .target (w_b_target)
    );

    assign w_next_pc = w_is_b ? w_b_target : w_seq_pc;
`else
    assign w_next_pc = w_seq_pc;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_ifid_pc <= '0;
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_running <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.Start) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= bus.StartPC;
                        r_running <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Redirect outranks halt, which outranks stall
                    if (bus.BranchTaken) begin
                        r_pc    <= bus.BranchTarget;
                        r_valid <= 1'b0;
                        if (bus.Halt) begin
                            r_state   <= ST_HALTED;
                            r_running <= 1'b0;
                        end
                    end else if (bus.Halt) begin
                        r_state   <= ST_HALTED;
                        r_running <= 1'b0;
                        r_valid   <= 1'b0;
                    end else if (!bus.Stall) begin
                        r_instr   <= bus.IMemData;
                        r_ifid_pc <= r_pc;
                        r_valid   <= 1'b1;
                        r_pc      <= w_next_pc;
                        if (r_count != {COUNT_W{1'b1}}) begin
                            r_count <= r_count + COUNT_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    r_valid <= 1'b0;
                    if (bus.Start) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_valid   <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IMemAddr   = r_pc;
    assign bus.IFID_Instr = r_instr;
    assign bus.IFID_PC    = r_ifid_pc;
    assign bus.IFID_Valid = r_valid;
    assign bus.FetchCount = r_count;
    assign bus.Running    = r_running;
endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_STEP, default 4, giving the byte increment per sequential fetch.
REQ-002 The block SHALL have parameter COUNT_W, default 32, giving the width of FetchCount.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port Start, input, 1 bit: begins fetching at StartPC.
REQ-007 The block SHALL have port StartPC, input, 64 bits: first fetch address.
REQ-008 The block SHALL have port Halt, input, 1 bit: stops fetching.
REQ-009 The block SHALL have port IMemData, input, 32 bits: instruction word returned combinationally by instruction memory for IMemAddr.
REQ-010 The block SHALL have port Stall, input, 1 bit: downstream cannot accept a new instruction.
REQ-011 The block SHALL have port BranchTaken, input, 1 bit: a resolved branch redirects fetch.
REQ-012 The block SHALL have port BranchTarget, input, 64 bits: redirect address, valid with BranchTaken.
REQ-013 The block SHALL have port IMemAddr, output, 64 bits: the current PC, driven to instruction memory.
REQ-014 The block SHALL have port IFID_Instr, output, 32 bits: registered instruction.
REQ-015 The block SHALL have port IFID_PC, output, 64 bits: the PC of IFID_Instr.
REQ-016 The block SHALL have port IFID_Valid, output, 1 bit: IFID_Instr holds a real instruction.
REQ-017 The block SHALL have port FetchCount, output, COUNT_W bits: count of instructions accepted into IF/ID.
REQ-018 The block SHALL have port Running, output, 1 bit: high only in state FETCH.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH and HALTED, with transitions IDLE->FETCH on Start, FETCH->HALTED on Halt, and HALTED->IDLE on Start.
REQ-020 On IDLE->FETCH the block SHALL load PC<=StartPC and SHALL leave IFID_Valid=0 for that cycle.
REQ-021 In FETCH with no Stall and no BranchTaken, each cycle SHALL set IFID_Instr<=IMemData, IFID_PC<=PC, IFID_Valid<=1 and PC<=PC+PC_STEP.
REQ-022 With Stall=1 and BranchTaken=0, PC and all IF/ID outputs SHALL hold and FetchCount SHALL not increment.
REQ-023 With BranchTaken=1, PC<=BranchTarget and IFID_Valid<=0 (flush), regardless of Stall.
REQ-024 Priority SHALL be Reset > BranchTaken > Halt > Stall > sequential.
REQ-025 Halt and BranchTaken asserted together SHALL update PC to BranchTarget and enter HALTED.
REQ-026 In IDLE and HALTED, IFID_Valid SHALL be 0 and PC SHALL hold.
REQ-027 FetchCount SHALL increment once per cycle in which IFID_Valid is loaded with 1, and SHALL saturate at all-ones.
REQ-028 PC arithmetic SHALL be 64-bit modulo 2^64, so 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-029 Fetch latency SHALL be one cycle: the instruction at PC appears on IFID_Instr after the next rising edge.

Reset
REQ-030 Reset SHALL force state IDLE, PC=0, IFID_Instr=0, IFID_PC=0, IFID_Valid=0, FetchCount=0 and Running=0.
REQ-031 Reset asserted mid-FETCH SHALL discard any in-flight instruction at the next edge and ignore all other inputs that cycle.

Configuration
REQ-032 When STATIC_BRANCH_PREDICT_EN is defined, a FETCH cycle whose IMemData[31:26]==6'b000101 (unconditional B) that is not stalled and not redirected SHALL load IF/ID normally and set PC<=PC+(SignExt(IMemData[25:0])<<2).
REQ-033 When STATIC_BRANCH_PREDICT_EN is undefined, B SHALL be fetched sequentially, and redirection SHALL occur only via BranchTaken.

Structure
REQ-034 A shared package fetch_pkg SHALL hold the FSM state typedef, the B opcode constant and the PC_STEP default.
REQ-035 Opcode detection and target computation SHALL be a sub-module named branch_predecode, instantiated only under STATIC_BRANCH_PREDICT_EN.

Verification
REQ-036 Reset, then Start with StartPC=0 and IMemData=AA1F03F4 -> next cycle IFID_Instr=AA1F03F4, IFID_PC=0, IFID_Valid=1, IMemAddr=4.
REQ-037 Stall held 3 cycles at PC=0x10 -> IMemAddr stays 0x10, IF/ID unchanged, FetchCount unchanged.
REQ-038 BranchTaken=1 with BranchTarget=0x20 and Stall=1 -> IMemAddr=0x20, IFID_Valid=0.
REQ-039 With STATIC_BRANCH_PREDICT_EN, IMemData=17FFFFFD at PC=0x2C -> IMemAddr=0x20 next cycle; without the macro -> IMemAddr=0x30.
REQ-040 Reset during FETCH at PC=0x18 -> IDLE, all outputs 0; Halt in FETCH -> HALTED, Running=0, PC held.
